// File: rtl/frame_buffer_pkg.sv
// Shared types and defaults for the double-buffered frame/config memory
// that sits between the SPI byte receiver and the charlieplex scanner.
package frame_buffer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2
   } wr_state_t;

   localparam int DEF_FRAME_BYTES = 8;
   localparam int DEF_CFG_BYTES   = 4;
   localparam int DEF_BYTE_W      = 8;
   localparam int DEF_ADDR_W      = 7;
   localparam int TOTAL_BYTES     = DEF_FRAME_BYTES + DEF_CFG_BYTES;
   localparam int AW_PTR          = DEF_ADDR_W;

   // The address byte's MSB requests a bank swap when the transaction ends.
   function automatic int swap_bit(input int byte_w);
      return byte_w - 1;
   endfunction

endpackage

// File: rtl/frame_write_ctrl.sv
// Write-side FSM: parses address byte + auto-incrementing data bytes and
// decodes each byte into a frame write, cfg write, or a dropped-byte flag.
module frame_write_ctrl
   import frame_buffer_pkg::*;
#(
   parameter int FRAME_BYTES = DEF_FRAME_BYTES,
   parameter int CFG_BYTES   = DEF_CFG_BYTES,
   parameter int BYTE_W      = DEF_BYTE_W,
   parameter int ADDR_W      = AW_PTR
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              byte_start,
   input  logic              byte_valid,
   input  logic [BYTE_W-1:0] byte_data,
   input  logic              byte_end,
   input  logic              swap_pending,
   output logic              frame_we,
   output logic              cfg_we,
   output logic [ADDR_W:0]   frame_idx,
   output logic [ADDR_W:0]   cfg_idx,
   output logic              set_overrun,
   output logic              set_addr_err,
   output logic              commit
);

   localparam int SWAP_BIT = swap_bit(BYTE_W);
   localparam logic [ADDR_W:0] FB_END  = (ADDR_W+1)'(FRAME_BYTES);
   localparam logic [ADDR_W:0] TOT_END = (ADDR_W+1)'(FRAME_BYTES + CFG_BYTES);

   wr_state_t         state;
   logic [ADDR_W-1:0] ptr;
   logic              swap_flag;
   logic [ADDR_W:0]   ptr_ext;
   logic              data_byte;
   logic              in_frame;
   logic              in_cfg;

   always_comb begin
      ptr_ext      = {1'b0, ptr};
      // byte_start wins over any same-cycle byte or end.
      data_byte    = (state == ST_DATA) && byte_valid && !byte_start;
      in_frame     = ptr_ext < FB_END;
      in_cfg       = !in_frame && (ptr_ext < TOT_END);
      frame_we     = data_byte && in_frame && !swap_pending;
      set_overrun  = data_byte && in_frame && swap_pending;
      cfg_we       = data_byte && in_cfg;
      set_addr_err = data_byte && !in_frame && !in_cfg;
      frame_idx    = ptr_ext;
      cfg_idx      = ptr_ext - FB_END;
      commit       = (state == ST_DATA) && byte_end && !byte_start && swap_flag;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         ptr       <= '0;
         swap_flag <= 1'b0;
      end else if (byte_start) begin
         state     <= ST_ADDR;
         swap_flag <= 1'b0;
      end else begin
         case (state)
            ST_ADDR: begin
               if (byte_valid) begin
                  ptr       <= byte_data[ADDR_W-1:0];
                  swap_flag <= byte_data[SWAP_BIT];
                  state     <= ST_DATA;
               end
               if (byte_end) state <= ST_IDLE;
            end
            ST_DATA: begin
               // Pointer saturates so a runaway stream keeps hitting addr_err.
               if (byte_valid && (ptr != {ADDR_W{1'b1}})) ptr <= ptr + 1'b1;
               if (byte_end) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/frame_buffer_bank.sv
// Double-buffered frame memory plus single-buffered config registers; the
// banks swap only on the scanner's frame_done so frames never tear.
module frame_buffer_bank
   import frame_buffer_pkg::*;
#(
   parameter int FRAME_BYTES = DEF_FRAME_BYTES,
   parameter int CFG_BYTES   = DEF_CFG_BYTES,
   parameter int BYTE_W      = DEF_BYTE_W,
   parameter int ADDR_W      = AW_PTR
) (
   input  logic                                         clk,
   input  logic                                         rst,
   input  logic                                         byte_start,
   input  logic                                         byte_valid,
   input  logic [BYTE_W-1:0]                            byte_data,
   input  logic                                         byte_end,
   input  logic                                         frame_done,
   input  logic                                         status_clr,
   output logic [FRAME_BYTES*BYTE_W-1:0]                frame_out,
   output logic [((CFG_BYTES > 0) ? CFG_BYTES : 1)*BYTE_W-1:0] cfg_out,
   output logic                                         swap_pending,
   output logic                                         front_sel,
   output logic [7:0]                                   swap_count,
   output logic                                         addr_err,
   output logic                                         overrun
);

   logic [FRAME_BYTES*BYTE_W-1:0] bank [2];
   logic            frame_we;
   logic            cfg_we;
   logic [ADDR_W:0] frame_idx;
   logic [ADDR_W:0] cfg_idx;
   logic            set_overrun;
   logic            set_addr_err;
   logic            commit;
   logic            swap_fire;

   frame_write_ctrl #(
      .FRAME_BYTES (FRAME_BYTES),
      .CFG_BYTES   (CFG_BYTES),
      .BYTE_W      (BYTE_W),
      .ADDR_W      (ADDR_W)
   ) u_ctrl (
      .clk          (clk),
      .rst          (rst),
      .byte_start   (byte_start),
      .byte_valid   (byte_valid),
      .byte_data    (byte_data),
      .byte_end     (byte_end),
      .swap_pending (swap_pending),
      .frame_we     (frame_we),
      .cfg_we       (cfg_we),
      .frame_idx    (frame_idx),
      .cfg_idx      (cfg_idx),
      .set_overrun  (set_overrun),
      .set_addr_err (set_addr_err),
      .commit       (commit)
   );

   assign swap_fire = frame_done && swap_pending;
   assign frame_out = bank[front_sel];

   always_ff @(posedge clk) begin
      if (rst) begin
         bank[0]      <= '0;
         bank[1]      <= '0;
         cfg_out      <= '0;
         front_sel    <= 1'b0;
         swap_pending <= 1'b0;
         swap_count   <= 8'd0;
         addr_err     <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         for (int i = 0; i < FRAME_BYTES; i++) begin
            if (frame_we && (frame_idx == (ADDR_W+1)'(i)))
               bank[~front_sel][i*BYTE_W +: BYTE_W] <= byte_data;
         end
         for (int i = 0; i < CFG_BYTES; i++) begin
            if (cfg_we && (cfg_idx == (ADDR_W+1)'(i)))
               cfg_out[i*BYTE_W +: BYTE_W] <= byte_data;
         end
         if (swap_fire) begin
            front_sel  <= ~front_sel;
            swap_count <= swap_count + 8'd1;
         end
         // A commit landing on the swap edge re-arms for the following frame.
         swap_pending <= commit | (swap_pending & ~frame_done);
         addr_err     <= set_addr_err | (addr_err & ~status_clr);
         overrun      <= set_overrun | (overrun & ~status_clr);
      end
   end

endmodule

// File: tb/tb_frame_buffer_bank.sv
// Self-checking bench for frame_buffer_bank against a transaction-level model.
module tb_frame_buffer_bank;

   logic        clk;
   logic        rst;
   logic        byte_start;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        byte_end;
   logic        frame_done;
   logic        status_clr;
   logic [63:0] frame_out;
   logic [31:0] cfg_out;
   logic        swap_pending;
   logic        front_sel;
   logic [7:0]  swap_count;
   logic        addr_err;
   logic        overrun;

   frame_buffer_bank dut (
      .clk          (clk),
      .rst          (rst),
      .byte_start   (byte_start),
      .byte_valid   (byte_valid),
      .byte_data    (byte_data),
      .byte_end     (byte_end),
      .frame_done   (frame_done),
      .status_clr   (status_clr),
      .frame_out    (frame_out),
      .cfg_out      (cfg_out),
      .swap_pending (swap_pending),
      .front_sel    (front_sel),
      .swap_count   (swap_count),
      .addr_err     (addr_err),
      .overrun      (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: banks as byte arrays, transaction-level updates.
   logic [7:0] m_bank [2][8];
   logic [7:0] m_cfg [4];
   bit         m_front, m_pend, m_aerr, m_ovr;
   int         m_count;
   logic [7:0] tx_q [$];

   task automatic mdl_reset();
      for (int b = 0; b < 2; b++) for (int i = 0; i < 8; i++) m_bank[b][i] = 8'h00;
      for (int i = 0; i < 4; i++) m_cfg[i] = 8'h00;
      m_front = 0; m_pend = 0; m_aerr = 0; m_ovr = 0; m_count = 0;
   endtask

   task automatic mdl_txn(input logic [7:0] addr, input bit ended);
      int p;
      p = int'(addr[6:0]);
      foreach (tx_q[k]) begin
         if (p < 8) begin
            if (m_pend) m_ovr = 1;
            else m_bank[m_front ? 0 : 1][p] = tx_q[k];
         end else if (p < 12) m_cfg[p-8] = tx_q[k];
         else m_aerr = 1;
         if (p < 127) p++;
      end
      if (ended && addr[7]) m_pend = 1;
   endtask

   task automatic mdl_done();
      if (m_pend) begin
         m_front = !m_front; m_count = (m_count + 1) % 256; m_pend = 0;
      end
   endtask

   function automatic logic [63:0] exp_frame();
      logic [63:0] r;
      for (int i = 0; i < 8; i++) r[i*8 +: 8] = m_bank[m_front ? 1 : 0][i];
      return r;
   endfunction

   function automatic logic [31:0] exp_cfg();
      logic [31:0] r;
      for (int i = 0; i < 4; i++) r[i*8 +: 8] = m_cfg[i];
      return r;
   endfunction

   // Driver tasks: inputs change 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic do_start();
      byte_start = 1; tick(); byte_start = 0;
   endtask

   task automatic do_byte(input logic [7:0] b);
      byte_valid = 1; byte_data = b; tick(); byte_valid = 0;
   endtask

   task automatic do_end();
      byte_end = 1; tick(); byte_end = 0;
   endtask

   task automatic do_done();
      frame_done = 1; tick(); frame_done = 0; mdl_done();
   endtask

   task automatic do_clr();
      status_clr = 1; tick(); status_clr = 0; m_aerr = 0; m_ovr = 0;
   endtask

   task automatic do_txn(input logic [7:0] addr);
      do_start(); do_byte(addr);
      foreach (tx_q[k]) do_byte(tx_q[k]);
      do_end(); mdl_txn(addr, 1);
   endtask

   task automatic test_reset();
      rst = 1; byte_start = 0; byte_valid = 0; byte_data = 0; byte_end = 0;
      frame_done = 0; status_clr = 0;
      tick(); tick(); rst = 0; mdl_reset();
      checks += 7;
      if (frame_out !== 64'h0) begin errors++; $display("FAIL reset_frame: got %h want 0", frame_out); end
      if (cfg_out !== 32'h0) begin errors++; $display("FAIL reset_cfg: got %h want 0", cfg_out); end
      if (front_sel !== 1'b0) begin errors++; $display("FAIL reset_front: got %b want 0", front_sel); end
      if (swap_count !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", swap_count); end
      if (swap_pending !== 1'b0) begin errors++; $display("FAIL reset_pending: got %b want 0", swap_pending); end
      if (addr_err !== 1'b0) begin errors++; $display("FAIL reset_addr_err: got %b want 0", addr_err); end
      if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun); end
   endtask

   task automatic test_frame_swap();
      tx_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
      do_txn(8'h80);
      checks += 2;
      if (swap_pending !== 1'b1) begin errors++; $display("FAIL swap_pending_set: got %b want 1", swap_pending); end
      if (front_sel !== 1'b0) begin errors++; $display("FAIL front_before_done: got %b want 0", front_sel); end
      do_done();
      checks += 4;
      if (front_sel !== 1'b1) begin errors++; $display("FAIL front_after_done: got %b want 1", front_sel); end
      if (frame_out !== 64'h0807060504030201) begin errors++; $display("FAIL frame_after_swap: got %h want 0807060504030201", frame_out); end
      if (swap_count !== 8'd1) begin errors++; $display("FAIL count_after_swap: got %0d want 1", swap_count); end
      if (swap_pending !== 1'b0) begin errors++; $display("FAIL pending_after_swap: got %b want 0", swap_pending); end
   endtask

   task automatic test_cfg_write();
      tx_q = '{8'hAA, 8'h55};
      do_txn(8'h08);
      checks += 3;
      if (cfg_out[15:0] !== 16'h55AA) begin errors++; $display("FAIL cfg_write: got %h want 55aa", cfg_out[15:0]); end
      if (swap_pending !== 1'b0) begin errors++; $display("FAIL cfg_no_pending: got %b want 0", swap_pending); end
      if (frame_out !== 64'h0807060504030201) begin errors++; $display("FAIL cfg_frame_kept: got %h want 0807060504030201", frame_out); end
   endtask

   task automatic test_overrun();
      tx_q = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28};
      do_txn(8'h80);
      tx_q = '{8'h11};
      do_txn(8'h80);
      checks += 1;
      if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b want 1", overrun); end
      do_done();
      checks += 2;
      if (frame_out !== 64'h2827262524232221) begin errors++; $display("FAIL overrun_bank_kept: got %h want 2827262524232221", frame_out); end
      if (frame_out !== exp_frame()) begin errors++; $display("FAIL overrun_model: got %h want %h", frame_out, exp_frame()); end
      do_clr();
      checks += 1;
      if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_clr: got %b want 0", overrun); end
   endtask

   task automatic test_addr_err();
      tx_q = '{8'h01, 8'h02};
      do_txn(8'h0B);
      checks += 2;
      if (cfg_out[31:24] !== 8'h01) begin errors++; $display("FAIL cfg3_write: got %h want 01", cfg_out[31:24]); end
      if (addr_err !== 1'b1) begin errors++; $display("FAIL addr_err_set: got %b want 1", addr_err); end
      do_clr();
      checks += 1;
      if (addr_err !== 1'b0) begin errors++; $display("FAIL addr_err_clr: got %b want 0", addr_err); end
      // Saturated pointer at the top, with a clear colliding with the set.
      do_start(); do_byte(8'h7F);
      status_clr = 1; byte_valid = 1; byte_data = 8'($urandom); tick();
      status_clr = 0; byte_valid = 0;
      do_byte(8'($urandom)); do_end();
      m_aerr = 1;
      checks += 1;
      if (addr_err !== 1'b1) begin errors++; $display("FAIL addr_err_set_wins: got %b want 1", addr_err); end
      do_clr();
   endtask

   task automatic test_done_same_cycle();
      tx_q.delete();
      for (int i = 0; i < 8; i++) tx_q.push_back(8'($urandom));
      do_start(); do_byte(8'h80);
      foreach (tx_q[k]) do_byte(tx_q[k]);
      byte_end = 1; frame_done = 1; tick(); byte_end = 0; frame_done = 0;
      mdl_txn(8'h80, 1);
      checks += 2;
      if (swap_pending !== 1'b1) begin errors++; $display("FAIL same_cycle_pending: got %b want 1", swap_pending); end
      if (front_sel !== m_front) begin errors++; $display("FAIL same_cycle_no_swap: got %b want %b", front_sel, m_front); end
      do_done();
      checks += 2;
      if (front_sel !== m_front) begin errors++; $display("FAIL same_cycle_later_swap: got %b want %b", front_sel, m_front); end
      if (frame_out !== exp_frame()) begin errors++; $display("FAIL same_cycle_frame: got %h want %h", frame_out, exp_frame()); end
   endtask

   task automatic test_abort();
      tx_q = '{8'hC1, 8'hC2, 8'hC3};
      do_start(); do_byte(8'h80);
      foreach (tx_q[k]) do_byte(tx_q[k]);
      mdl_txn(8'h80, 0);
      // Restart with a colliding byte that must be discarded.
      byte_start = 1; byte_valid = 1; byte_data = 8'h80; tick();
      byte_start = 0; byte_valid = 0;
      tx_q = '{8'h99};
      do_byte(8'h00); do_byte(8'h99); do_end(); mdl_txn(8'h00, 1);
      checks += 1;
      if (swap_pending !== 1'b0) begin errors++; $display("FAIL abort_no_commit: got %b want 0", swap_pending); end
      tx_q.delete();
      do_txn(8'h80);
      do_done();
      checks += 1;
      if (frame_out !== exp_frame()) begin errors++; $display("FAIL abort_bank_kept: got %h want %h", frame_out, exp_frame()); end
   endtask

   task automatic test_reset_pending();
      tx_q.delete();
      for (int i = 0; i < 8; i++) tx_q.push_back(8'($urandom));
      do_txn(8'h80);
      rst = 1; frame_done = 1; tick(); frame_done = 0; tick(); rst = 0;
      mdl_reset();
      checks += 4;
      if (front_sel !== 1'b0) begin errors++; $display("FAIL rst_pending_front: got %b want 0", front_sel); end
      if (swap_pending !== 1'b0) begin errors++; $display("FAIL rst_pending_clear: got %b want 0", swap_pending); end
      if (swap_count !== 8'd0) begin errors++; $display("FAIL rst_pending_count: got %0d want 0", swap_count); end
      if (frame_out !== 64'h0) begin errors++; $display("FAIL rst_pending_frame: got %h want 0", frame_out); end
   endtask

   task automatic test_random();
      logic [7:0] addr;
      for (int it = 0; it < 40; it++) begin
         addr[7] = 1'($urandom);
         addr[6:0] = ($urandom_range(0, 5) == 0) ? 7'($urandom_range(120, 127))
                                                  : 7'($urandom_range(0, 14));
         tx_q.delete();
         for (int i = 0; i < $urandom_range(0, 10); i++) tx_q.push_back(8'($urandom));
         do_txn(addr);
         if ($urandom_range(0, 1) == 1) do_done();
         if ($urandom_range(0, 4) == 0) do_clr();
         checks += 7;
         if (frame_out !== exp_frame()) begin errors++; $display("FAIL rnd_frame it%0d: got %h want %h", it, frame_out, exp_frame()); end
         if (cfg_out !== exp_cfg()) begin errors++; $display("FAIL rnd_cfg it%0d: got %h want %h", it, cfg_out, exp_cfg()); end
         if (swap_pending !== m_pend) begin errors++; $display("FAIL rnd_pending it%0d: got %b want %b", it, swap_pending, m_pend); end
         if (front_sel !== m_front) begin errors++; $display("FAIL rnd_front it%0d: got %b want %b", it, front_sel, m_front); end
         if (swap_count !== 8'(m_count)) begin errors++; $display("FAIL rnd_count it%0d: got %0d want %0d", it, swap_count, m_count); end
         if (addr_err !== m_aerr) begin errors++; $display("FAIL rnd_addr_err it%0d: got %b want %b", it, addr_err, m_aerr); end
         if (overrun !== m_ovr) begin errors++; $display("FAIL rnd_overrun it%0d: got %b want %b", it, overrun, m_ovr); end
      end
   endtask

   initial begin
      test_reset();
      test_frame_swap();
      test_cfg_write();
      test_overrun();
      test_addr_err();
      test_done_same_cycle();
      test_abort();
      test_reset_pending();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
